lsu_sram_ctrl: RTL and testbench

- Load/store initiator that drives the word-wide synchronous data SRAM on behalf of the core.
- Converts byte, halfword and word loads/stores (RISC-V funct3 encoding) into SRAM word accesses.
- Loads are extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write.
- Sits between the execute stage and the data memory. The core stalls on o_busy.

---
 rtl/lsu_sram_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lsu_sram_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sram_ctrl.sv
// Load/store unit front-end for a word-wide synchronous data SRAM.
// Accepts byte/halfword/word loads and stores (RISC-V funct3 encoding) from
// the execute stage. Loads are extracted and extended from a single SRAM read.
// Sub-word stores are performed as read-modify-write. The core stalls on o_busy.
module lsu_sram_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int RD_LAT    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic        o_busy,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
    localparam logic [1:0]  CNT_LAST    = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;

    // Request captured at acceptance; immune to later input changes.
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  funct3_reg;
    logic        err_reg;

    // SRAM word captured on the last read-latency cycle.
    logic [31:0] word_reg;

    logic        funct3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        word_store;

    logic [31:0] sb_word;
    logic [31:0] sh_word;
    logic [31:0] store_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_word;

    // Legality check of the incoming request, evaluated against the live inputs in IDLE.
    always_comb begin
        if (i_we) begin
            // Stores: only SB, SH, SW exist.
            funct3_bad = i_funct3[2] | (i_funct3[1:0] == 2'b11);
        end else begin
            // Loads: 011, 110 and 111 are undefined.
            funct3_bad = (i_funct3[1:0] == 2'b11) | (i_funct3[2] & i_funct3[1]);
        end
        misaligned   = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                       ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, i_addr[31:2]} >= MEM_WORDS_W);
        req_err      = funct3_bad | misaligned | out_of_range;
        word_store   = i_we & (i_funct3 == 3'b010);
    end

    // State and read-latency counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Latch the request and its legality verdict on acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_reg     <= 1'b0;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            funct3_reg <= 3'd0;
            err_reg    <= 1'b0;
        end else if (state_reg == IDLE && i_req) begin
            we_reg     <= i_we;
            addr_reg   <= i_addr;
            wdata_reg  <= i_wdata;
            funct3_reg <= i_funct3;
            err_reg    <= req_err;
        end
    end

    // Capture SRAM read data on the final latency cycle of RD.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_reg <= 32'd0;
        end else if (state_reg == RD && cnt_reg == CNT_LAST) begin
            word_reg <= i_mem_rdata;
        end
    end

    // Byte-lane merge for SB: only the addressed lane takes the new data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sb_lane
            assign sb_word[8*gi +: 8] = (addr_reg[1:0] == 2'(gi)) ? wdata_reg[7:0]
                                                                  : word_reg[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_sh_lane
            assign sh_word[16*gi +: 16] = (addr_reg[1] == 1'(gi)) ? wdata_reg[15:0]
                                                                  : word_reg[16*gi +: 16];
        end
    endgenerate

    // Select the write word and build the extended load result.
    always_comb begin
        case (funct3_reg[1:0])
            2'b00:   store_word = sb_word;
            2'b01:   store_word = sh_word;
            default: store_word = wdata_reg;
        endcase

        ld_byte = word_reg[{addr_reg[1:0], 3'b000} +: 8];
        ld_half = word_reg[{addr_reg[1], 4'b0000} +: 16];
        case (funct3_reg)
            3'b000:  load_word = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_word = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_word = {24'd0, ld_byte};
            3'b101:  load_word = {16'd0, ld_half};
            default: load_word = word_reg;
        endcase
    end

    // Next-state logic and state-decoded outputs (no input-to-output paths).
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        o_busy      = (state_reg != IDLE);
        o_ack       = 1'b0;
        o_err       = 1'b0;
        o_rdata     = 32'd0;
        o_mem_addr  = 32'd0;
        o_mem_wren  = 1'b0;
        o_mem_wdata = 32'd0;

        case (state_reg)
            IDLE: begin
                cnt_next = 2'd0;
                if (i_req) begin
                    if (req_err) begin
                        state_next = DONE;
                    end else if (word_store) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                o_mem_addr = {2'b00, addr_reg[31:2]};
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = 2'd0;
                    state_next = we_reg ? WR : DONE;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            WR: begin
                o_mem_addr  = {2'b00, addr_reg[31:2]};
                o_mem_wren  = 1'b1;
                o_mem_wdata = store_word;
                state_next  = DONE;
            end
            DONE: begin
                o_ack = 1'b1;
                o_err = err_reg;
                if (!err_reg && !we_reg) begin
                    o_rdata = load_word;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Self-checking bench for lsu_sram_ctrl: two instances (RD_LAT=1 and RD_LAT=3)
// each paired with a behavioural SRAM; expected results go through a scoreboard queue.
`timescale 1ns/1ps
module tb_lsu_sram_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_a, req_b;
    logic        we;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;

    logic        busy_a, ack_a, err_a, wren_a;
    logic [31:0] rdata_a, maddr_a, mwdata_a, mrdata_a;
    logic        busy_b, ack_b, err_b, wren_b;
    logic [31:0] rdata_b, maddr_b, mwdata_b, mrdata_b;

    lsu_sram_ctrl #(.MEM_WORDS(1024), .RD_LAT(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_funct3(funct3), .o_busy(busy_a), .o_ack(ack_a),
        .o_rdata(rdata_a), .o_err(err_a), .o_mem_addr(maddr_a), .o_mem_wren(wren_a),
        .o_mem_wdata(mwdata_a), .i_mem_rdata(mrdata_a)
    );

    lsu_sram_ctrl #(.MEM_WORDS(1024), .RD_LAT(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_funct3(funct3), .o_busy(busy_b), .o_ack(ack_b),
        .o_rdata(rdata_b), .o_err(err_b), .o_mem_addr(maddr_b), .o_mem_wren(wren_b),
        .o_mem_wdata(mwdata_b), .i_mem_rdata(mrdata_b)
    );

    // SRAM models: A reads with one cycle of latency, B with three (two extra stages).
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] pipe_b1, pipe_b2;
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (wren_a) mem_a[maddr_a[9:0]] <= mwdata_a;
        else if (pre_we) mem_a[pre_idx] <= pre_data;
        if (wren_b) mem_b[maddr_b[9:0]] <= mwdata_b;
        else if (pre_we) mem_b[pre_idx] <= pre_data;
        pipe_b1 <= mem_b[maddr_b[9:0]];
        pipe_b2 <= pipe_b1;
    end
    assign mrdata_a = mem_a[maddr_a[9:0]];
    assign mrdata_b = pipe_b2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwren;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Drive one request into dut_a and observe it until ack (bounded); lat = edges after accept.
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           input logic [2:0] t_f3, output int lat, output logic [31:0] rd,
                           output logic er, output int nw, output logic [31:0] waddr,
                           output logic [31:0] wdat);
        bit done;
        @(negedge clk);
        we = t_we; addr = t_addr; wdata = t_wdata; funct3 = t_f3; req_a = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        we = ~t_we; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        lat = -1; rd = 32'd0; er = 1'b0; nw = 0; waddr = 32'd0; wdat = 32'd0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (wren_a) begin
                nw++; waddr = maddr_a; wdat = mwdata_a;
            end
            if (ack_a) begin
                rd = rdata_a; er = err_a; lat = i; done = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_checks++;
        if ({busy_a, ack_a, err_a, wren_a, rdata_a, maddr_a, mwdata_a,
             busy_b, ack_b, err_b, wren_b, rdata_b, maddr_b, mwdata_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_in: outputs a=%h/%h/%h b=%h/%h/%h expected all zero",
                     {busy_a, ack_a, err_a, wren_a}, rdata_a, maddr_a,
                     {busy_b, ack_b, err_b, wren_b}, rdata_b, maddr_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy_a, ack_a, err_a, wren_a, rdata_a, maddr_a, mwdata_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: busy/ack/err/wren=%b rdata=%h maddr=%h wdata=%h expected all zero",
                     {busy_a, ack_a, err_a, wren_a}, rdata_a, maddr_a, mwdata_a);
        end
    endtask

    task automatic test_word();
        int lat, nw; logic [31:0] rd, wa, wd; logic er; exp_t e;
        sb_q.push_back('{rdata: 32'd0, err: 1'b0, lat: 1, nwren: 1});
        run_txn(1'b1, 32'h40, 32'hDEADBEEF, 3'b010, lat, rd, er, nw, wa, wd);
        e = sb_q.pop_front();
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL sw_lat: got %0d expected %0d", lat, e.lat); end
        n_checks++; if (nw !== e.nwren) begin n_fail++; $display("FAIL sw_wren_cycles: got %0d expected %0d", nw, e.nwren); end
        n_checks++; if (wa !== 32'h10) begin n_fail++; $display("FAIL sw_mem_addr: got %h expected 00000010", wa); end
        n_checks++; if ({er, rd} !== {e.err, e.rdata}) begin n_fail++; $display("FAIL sw_err_rdata: got %b/%h expected %b/%h", er, rd, e.err, e.rdata); end
        n_checks++; if (mem_a[16] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem: got %h expected deadbeef", mem_a[16]); end

        sb_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, lat: 1, nwren: 0});
        run_txn(1'b0, 32'h40, 32'h0, 3'b010, lat, rd, er, nw, wa, wd);
        e = sb_q.pop_front();
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL lw_lat: got %0d expected %0d", lat, e.lat); end
        n_checks++; if ({er, rd} !== {e.err, e.rdata}) begin n_fail++; $display("FAIL lw_rdata: got %b/%h expected %b/%h", er, rd, e.err, e.rdata); end
        n_checks++; if (nw !== e.nwren) begin n_fail++; $display("FAIL lw_wren_cycles: got %0d expected %0d", nw, e.nwren); end
    endtask

    task automatic test_loads();
        logic [31:0] t_addr [8] = '{32'h43, 32'h43, 32'h42, 32'h40, 32'h40, 32'h42, 32'h41, 32'h42};
        logic [2:0]  t_f3   [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b101, 3'b000, 3'b100};
        logic [31:0] t_exp  [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                    32'h00000001, 32'h000080FF, 32'h0000007F, 32'h000000FF};
        int lat, nw; logic [31:0] rd, wa, wd; logic er; exp_t e;
        preload(10'd16, 32'h80FF7F01);
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{rdata: t_exp[i], err: 1'b0, lat: 1, nwren: 0});
            run_txn(1'b0, t_addr[i], 32'h0, t_f3[i], lat, rd, er, nw, wa, wd);
            e = sb_q.pop_front();
            n_checks++;
            if ({er, rd} !== {e.err, e.rdata} || lat !== e.lat || nw !== e.nwren) begin
                n_fail++;
                $display("FAIL load_%0d f3=%b addr=%h: got err=%b rdata=%h lat=%0d wren=%0d expected err=%b rdata=%h lat=%0d wren=%0d",
                         i, t_f3[i], t_addr[i], er, rd, lat, nw, e.err, e.rdata, e.lat, e.nwren);
            end
        end
    endtask

    task automatic test_subword();
        logic        t_we   [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] t_addr [4] = '{32'h41, 32'h42, 32'h43, 32'h40};
        logic [31:0] t_wd   [4] = '{32'hFFFFFFAA, 32'h00005566, 32'h12345677, 32'hAAAABEEF};
        logic [2:0]  t_f3   [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
        logic [31:0] t_mem  [4] = '{32'h1122AA44, 32'h5566AA44, 32'h7766AA44, 32'h7766BEEF};
        int lat, nw; logic [31:0] rd, wa, wd; logic er; exp_t e;
        preload(10'd16, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{rdata: 32'd0, err: 1'b0, lat: 2, nwren: 1});
            run_txn(t_we[i], t_addr[i], t_wd[i], t_f3[i], lat, rd, er, nw, wa, wd);
            e = sb_q.pop_front();
            n_checks++;
            if ({er, rd} !== {e.err, e.rdata} || lat !== e.lat || nw !== e.nwren || wa !== 32'h10) begin
                n_fail++;
                $display("FAIL substore_%0d: got err=%b rdata=%h lat=%0d wren=%0d maddr=%h expected err=%b rdata=%h lat=%0d wren=%0d maddr=00000010",
                         i, er, rd, lat, nw, wa, e.err, e.rdata, e.lat, e.nwren);
            end
            n_checks++;
            if (mem_a[16] !== t_mem[i]) begin
                n_fail++;
                $display("FAIL substore_mem_%0d: got %h expected %h", i, mem_a[16], t_mem[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        t_we   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] t_addr [5] = '{32'h42, 32'h41, 32'h40, 32'h1000, 32'h40};
        logic [2:0]  t_f3   [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
        int lat, nw; logic [31:0] rd, wa, wd, snap; logic er; exp_t e;
        preload(10'd16, 32'h0F1E2D3C);
        snap = 32'h0F1E2D3C;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{rdata: 32'd0, err: 1'b1, lat: 0, nwren: 0});
            run_txn(t_we[i], t_addr[i], 32'hFFFFFFFF, t_f3[i], lat, rd, er, nw, wa, wd);
            e = sb_q.pop_front();
            n_checks++;
            if ({er, rd} !== {e.err, e.rdata} || lat !== e.lat || nw !== e.nwren) begin
                n_fail++;
                $display("FAIL error_%0d we=%b addr=%h f3=%b: got err=%b rdata=%h lat=%0d wren=%0d expected err=%b rdata=%h lat=%0d wren=%0d",
                         i, t_we[i], t_addr[i], t_f3[i], er, rd, lat, nw, e.err, e.rdata, e.lat, e.nwren);
            end
            n_checks++;
            if (mem_a[16] !== snap) begin
                n_fail++;
                $display("FAIL error_mem_%0d: got %h expected %h", i, mem_a[16], snap);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, nw, bad; logic [31:0] rd, wa, wd; logic er; exp_t e;
        preload(10'd16, 32'hCAFEF00D);
        @(negedge clk);
        we = 1'b1; addr = 32'h40; wdata = 32'h00000012; funct3 = 3'b000; req_a = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1 || maddr_a !== 32'h10) begin
            n_fail++;
            $display("FAIL midrst_in_rd: got busy=%b maddr=%h expected busy=1 maddr=00000010", busy_a, maddr_a);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_a, ack_a, err_a, wren_a, rdata_a, maddr_a, mwdata_a} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy/ack/err/wren=%b rdata=%h maddr=%h wdata=%h expected all zero",
                     {busy_a, ack_a, err_a, wren_a}, rdata_a, maddr_a, mwdata_a);
        end
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (ack_a || wren_a || busy_a) bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack_a || wren_a || busy_a) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
        n_checks++;
        if (mem_a[16] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midrst_mem: got %h expected cafef00d", mem_a[16]); end

        sb_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, lat: 1, nwren: 0});
        run_txn(1'b0, 32'h40, 32'h0, 3'b010, lat, rd, er, nw, wa, wd);
        e = sb_q.pop_front();
        n_checks++;
        if ({er, rd} !== {e.err, e.rdata} || lat !== e.lat || nw !== e.nwren) begin
            n_fail++;
            $display("FAIL midrst_reload: got err=%b rdata=%h lat=%0d wren=%0d expected err=%b rdata=%h lat=%0d wren=%0d",
                     er, rd, lat, nw, e.err, e.rdata, e.lat, e.nwren);
        end
    endtask

    // Hold i_req for 10 cycles: a new load is accepted every RD_LAT+2 cycles.
    task automatic test_hold_req(input int rl);
        int p, n_acc, end_c;
        logic o_busy_s, o_ack_s; logic [31:0] o_rd_s; logic exp_busy, exp_ack; exp_t e;
        p     = rl + 2;
        n_acc = 9 / p + 1;
        end_c = (n_acc - 1) * p + p;
        preload(10'd16, 32'h0BADC0DE);
        @(negedge clk);
        we = 1'b0; addr = 32'h40; wdata = 32'h0; funct3 = 3'b010;
        for (int c = 0; c <= end_c; c++) begin
            if (c > 0) @(negedge clk);
            if (rl == 1) req_a = (c < 10); else req_b = (c < 10);
            o_busy_s = (rl == 1) ? busy_a : busy_b;
            o_ack_s  = (rl == 1) ? ack_a  : ack_b;
            o_rd_s   = (rl == 1) ? rdata_a : rdata_b;
            if (c % p == 0 && c < 10) sb_q.push_back('{rdata: 32'h0BADC0DE, err: 1'b0, lat: rl, nwren: 0});
            exp_busy = (c % p != 0);
            exp_ack  = (c % p == p - 1);
            n_checks++;
            if (o_busy_s !== exp_busy || o_ack_s !== exp_ack) begin
                n_fail++;
                $display("FAIL hold_lat%0d_cycle%0d: got busy=%b ack=%b expected busy=%b ack=%b",
                         rl, c, o_busy_s, o_ack_s, exp_busy, exp_ack);
            end
            if (o_ack_s === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL hold_lat%0d_extra_ack: got ack at cycle %0d expected none", rl, c);
                end else begin
                    e = sb_q.pop_front();
                    if (o_rd_s !== e.rdata) begin
                        n_fail++;
                        $display("FAIL hold_lat%0d_rdata: got %h expected %h", rl, o_rd_s, e.rdata);
                    end
                end
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL hold_lat%0d_missing_acks: got %0d outstanding expected 0", rl, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we = 1'b0;
        addr = 32'd0; wdata = 32'd0; funct3 = 3'd0;
        pre_we = 1'b0; pre_idx = 10'd0; pre_data = 32'd0;
        test_reset();
        test_word();
        test_loads();
        test_subword();
        test_errors();
        test_reset_mid();
        test_hold_req(1);
        test_hold_req(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
